exmem_stage: RTL and testbench
==============================

# exmem_stage

Parametrised EX/MEM pipeline stage with valid/ready handshake, synchronous flush, store-data byte-lane alignment and an EX/MEM forwarding tap. It sits between the execute stage and the data-memory port. It replaces the plain always-enabled EX/MEM register so the pipeline can stall on memory back-pressure and squash on branch redirect.

## Interface
- WordSize, 32, datapath width; legal values 32 or 64.
- RegAddrW, 5, register-index width.
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  EX holds a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- rdn_in  input  RegAddrW  destination register.
- alu_out_in  input  WordSize  ALU result / effective address.
- rs2d  input  WordSize  store source data.
- branch_taken_in  input  1  branch resolved taken.
- mem_op_in  input  2  mem_op_t: NONE=0, LOAD=1, STORE=2.
- mem_size_in  input  2  mem_size_t: BYTE=0, HALF=1, WORD=2 (4 bytes).
- flush  input  1  squash all held entries.
- out_valid  output  1  MEM slot valid.
- out_ready  input  1  MEM consumes this cycle.
- rdn, alu_out, mem_data, branch_taken, mem_op  output  registered payload.
- mem_be  output  WordSize/8  store byte enables.
- misalign  output  1  registered misaligned-access flag.
- fwd_valid, fwd_rdn, fwd_data  output  1 / RegAddrW / WordSize  forwarding tap.

## Operation
- Accept on in_valid && in_ready. Retire on out_valid && out_ready.
- Alignment is computed at the input and registered with the payload:
  - off = alu_out_in[log2(WordSize/8)-1:0].
  - mem_data = rs2d << (8*off).
  - mem_be = size mask (1/3/0xF) << off, but only for STORE; otherwise 0.
  - misalign = 1 when off is not a multiple of the access size and mem_op_in != NONE; mem_be is forced to 0 in that case.
- branch_taken, mem_be and fwd_valid are gated by out_valid; they are never 1 while out_valid = 0.
- fwd_valid = out_valid && fwd_rdn != 0 && mem_op != LOAD. fwd_rdn = rdn and fwd_data = alu_out.
- Flush:
  - Clears every valid bit at the next edge.
  - An input accepted in the same cycle is discarded; flush wins over accept and over retire.
  - Payload registers keep their values; only the valid bits clear.
- Stall: while out_valid && !out_ready, the output payload holds stable.

## Timing
- Latency: accept at edge N gives out_valid with payload at edge N+1.
- Throughput: one transfer per cycle when out_ready = 1.
- Reset values:
  - out_valid, fwd_valid, branch_taken, misalign = 0.
  - rdn, alu_out, mem_data, mem_op, mem_be = 0.
  - in_ready = 1.
- Reset asserted mid-stall drops all held entries immediately (asynchronous); nothing is replayed.
- Empty stage with in_valid = 0: out_valid falls after the current entry retires.

## Configuration
- EXMEM_SKID_EN defined:
  - Adds a second skid slot. in_ready is registered: in_ready = !skid_valid.
  - When the output is full and not retiring, one further accept lands in the skid slot.
  - The skid entry moves to the output slot on the next retire, so there is no bubble.
  - Full means both slots valid; in that state in_ready = 0.
- EXMEM_SKID_EN undefined:
  - Single slot. in_ready = !out_valid || out_ready, combinational from out_ready.
- Payload ordering and flush semantics are identical in both builds.

## Structure
- Package exmem_pkg holds:
  - mem_op_t and mem_size_t enums.
  - exmem_payload_t struct (rdn, alu_out, mem_data, branch_taken, mem_op, mem_be, misalign), parametrised via WordSize localparams.
  - The size-mask constants.
- Sub-module exmem_store_align (combinational): rs2d, off, size, op -> mem_data, mem_be, misalign.
- Instantiated once, before the slot registers.

## Test plan
- Reset, then STORE HALF, alu_out_in = 0x1002, rs2d = 0x0000ABCD.
  - Next cycle: out_valid = 1, mem_data = 0xABCD0000, mem_be = 0b1100, misalign = 0.
- STORE WORD, alu_out_in = 0x1001.
  - misalign = 1, mem_be = 0.
- LOAD with rdn_in = 7, then ALU op with rdn_in = 7.
  - fwd_valid = 0 for the LOAD and 1 for the ALU op; rdn_in = 0 always gives fwd_valid = 0.
- out_ready = 0 for 3 cycles with a continuous stream.
  - Skid build: accepts exactly 2 entries, then in_ready = 0; all entries emerge in order with no loss or duplication.
  - Non-skid build: accepts 1.
- flush while the output is valid and in_valid = 1.
  - Next cycle out_valid = 0, and the flushed input never appears.
- rstn dropped asynchronously mid-stall.
  - All outputs 0 before the next clock edge; in_ready = 1 once released.

Source files
------------

// File: rtl/exmem_pkg.sv
// Shared types and constants for the EX/MEM pipeline stage.
// Payload fields are sized for the widest legal datapath; narrower builds use the low bits.
package exmem_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  localparam int MaxWordSize = 64;
  localparam int MaxBeW      = MaxWordSize / 8;
  localparam int MaxRegAddrW = 8;

  localparam logic [7:0] MaskByte = 8'h01;
  localparam logic [7:0] MaskHalf = 8'h03;
  localparam logic [7:0] MaskWord = 8'h0F;

  typedef struct packed {
    logic [MaxRegAddrW-1:0] rdn;
    logic [MaxWordSize-1:0] alu_out;
    logic [MaxWordSize-1:0] mem_data;
    logic                   branch_taken;
    mem_op_t                mem_op;
    logic [MaxBeW-1:0]      mem_be;
    logic                   misalign;
  } exmem_payload_t;

  function automatic logic [7:0] sizeMask(input mem_size_t size);
    case (size)
      SIZE_BYTE: return MaskByte;
      SIZE_HALF: return MaskHalf;
      SIZE_WORD: return MaskWord;
      default:   return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/exmem_if.sv
// Handshake and payload bundle between EX, the EX/MEM stage and the memory port.
// The stage connects through 'slave'; whoever drives EX and consumes MEM uses 'master'.
interface exmem_if #(
  parameter int WordSize = 32,
  parameter int RegAddrW = 5
);
  import exmem_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [RegAddrW-1:0]   rdn_in;
  logic [WordSize-1:0]   alu_out_in;
  logic [WordSize-1:0]   rs2d;
  logic                  branch_taken_in;
  mem_op_t               mem_op_in;
  mem_size_t             mem_size_in;
  logic                  flush;

  logic                  out_valid;
  logic                  out_ready;
  logic [RegAddrW-1:0]   rdn;
  logic [WordSize-1:0]   alu_out;
  logic [WordSize-1:0]   mem_data;
  logic                  branch_taken;
  mem_op_t               mem_op;
  logic [WordSize/8-1:0] mem_be;
  logic                  misalign;

  logic                  fwd_valid;
  logic [RegAddrW-1:0]   fwd_rdn;
  logic [WordSize-1:0]   fwd_data;

  modport slave (
    input  in_valid, rdn_in, alu_out_in, rs2d, branch_taken_in, mem_op_in, mem_size_in,
    input  flush, out_ready,
    output in_ready, out_valid, rdn, alu_out, mem_data, branch_taken, mem_op, mem_be,
    output misalign, fwd_valid, fwd_rdn, fwd_data
  );

  modport master (
    output in_valid, rdn_in, alu_out_in, rs2d, branch_taken_in, mem_op_in, mem_size_in,
    output flush, out_ready,
    input  in_ready, out_valid, rdn, alu_out, mem_data, branch_taken, mem_op, mem_be,
    input  misalign, fwd_valid, fwd_rdn, fwd_data
  );

endinterface

// File: rtl/exmem_store_align.sv
// Combinational store-lane alignment: shifts store data and byte enables to the address
// offset and flags accesses whose offset is not a multiple of the access size.
module exmem_store_align
  import exmem_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic [WordSize-1:0]           rs2d_i,
  input  logic [$clog2(WordSize/8)-1:0] off_i,
  input  mem_size_t                     size_i,
  input  mem_op_t                       op_i,
  output logic [WordSize-1:0]           mem_data_o,
  output logic [WordSize/8-1:0]         mem_be_o,
  output logic                          misalign_o
);

  localparam int BeW = WordSize / 8;

  logic offOdd;

  always_comb begin
    offOdd = 1'b0;
    case (size_i)
      SIZE_HALF: offOdd = off_i[0];
      SIZE_WORD: offOdd = |off_i[1:0];
      default:   offOdd = 1'b0;
    endcase
  end

  assign misalign_o = offOdd && (op_i != MEM_NONE);
  assign mem_data_o = rs2d_i << {off_i, 3'b000};

  // Loads and misaligned stores never drive byte lanes.
  assign mem_be_o = (op_i == MEM_STORE && !misalign_o) ? (BeW'(sizeMask(size_i)) << off_i)
                                                       : '0;

endmodule

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush, store alignment and forwarding tap.
// Define EXMEM_SKID_EN to add a second (skid) slot and register in_ready.
module exmem_stage
  import exmem_pkg::*;
#(
  parameter int WordSize = 32,
  parameter int RegAddrW = 5
) (
  input logic     clk,
  input logic     rstn,
  exmem_if.slave  bus
);

  localparam int BeW  = WordSize / 8;
  localparam int OffW = $clog2(BeW);

  logic [WordSize-1:0] alignData;
  logic [BeW-1:0]      alignBe;
  logic                alignMis;
  exmem_payload_t      inPay;

  exmem_store_align #(.WordSize(WordSize)) uAlign (
    .rs2d_i     (bus.rs2d),
    .off_i      (bus.alu_out_in[OffW-1:0]),
    .size_i     (bus.mem_size_in),
    .op_i       (bus.mem_op_in),
    .mem_data_o (alignData),
    .mem_be_o   (alignBe),
    .misalign_o (alignMis)
  );

  always_comb begin
    inPay              = '0;
    inPay.rdn          = MaxRegAddrW'(bus.rdn_in);
    inPay.alu_out      = MaxWordSize'(bus.alu_out_in);
    inPay.mem_data     = MaxWordSize'(alignData);
    inPay.branch_taken = bus.branch_taken_in;
    inPay.mem_op       = bus.mem_op_in;
    inPay.mem_be       = MaxBeW'(alignBe);
    inPay.misalign     = alignMis;
  end

  exmem_payload_t outSlot_q, outSlot_d;
  logic           outValid_q, outValid_d;
  logic           accept, retire, inReady;

  assign accept = bus.in_valid && inReady;
  assign retire = outValid_q && bus.out_ready;

`ifdef EXMEM_SKID_EN
  exmem_payload_t skidSlot_q, skidSlot_d;
  logic           skidValid_q, skidValid_d;

  assign inReady = !skidValid_q;

  // A retire first promotes the skid entry; a new accept then fills whichever slot is free.
  always_comb begin
    outSlot_d   = outSlot_q;
    outValid_d  = outValid_q;
    skidSlot_d  = skidSlot_q;
    skidValid_d = skidValid_q;
    if (bus.flush) begin
      outValid_d  = 1'b0;
      skidValid_d = 1'b0;
    end else begin
      if (retire) begin
        if (skidValid_q) begin
          outSlot_d   = skidSlot_q;
          skidValid_d = 1'b0;
        end else begin
          outValid_d = 1'b0;
        end
      end
      if (accept) begin
        if (!outValid_d) begin
          outSlot_d  = inPay;
          outValid_d = 1'b1;
        end else begin
          skidSlot_d  = inPay;
          skidValid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skidSlot_q  <= '0;
      skidValid_q <= 1'b0;
    end else begin
      skidSlot_q  <= skidSlot_d;
      skidValid_q <= skidValid_d;
    end
  end
`else
  assign inReady = !outValid_q || bus.out_ready;

  always_comb begin
    outSlot_d  = outSlot_q;
    outValid_d = outValid_q;
    if (bus.flush) begin
      outValid_d = 1'b0;
    end else if (accept) begin
      outSlot_d  = inPay;
      outValid_d = 1'b1;
    end else if (retire) begin
      outValid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outSlot_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      outSlot_q  <= outSlot_d;
      outValid_q <= outValid_d;
    end
  end

  logic [RegAddrW-1:0] outRdn;
  logic                unusedWideBits;

  assign outRdn         = outSlot_q.rdn[RegAddrW-1:0];
  assign unusedWideBits = ^{outSlot_q.rdn, outSlot_q.alu_out, outSlot_q.mem_data, outSlot_q.mem_be};

  assign bus.in_ready     = inReady;
  assign bus.out_valid    = outValid_q;
  assign bus.rdn          = outRdn;
  assign bus.alu_out      = outSlot_q.alu_out[WordSize-1:0];
  assign bus.mem_data     = outSlot_q.mem_data[WordSize-1:0];
  assign bus.mem_op       = outSlot_q.mem_op;
  assign bus.misalign     = outSlot_q.misalign;
  assign bus.branch_taken = outValid_q && outSlot_q.branch_taken;
  assign bus.mem_be       = outValid_q ? outSlot_q.mem_be[BeW-1:0] : '0;

  // Loads cannot forward from here: their data only exists after the memory access.
  assign bus.fwd_valid = outValid_q && (outRdn != '0) && (outSlot_q.mem_op != MEM_LOAD);
  assign bus.fwd_rdn   = outRdn;
  assign bus.fwd_data  = outSlot_q.alu_out[WordSize-1:0];

endmodule

// File: tb/tb_exmem_stage.sv
// Self-checking bench for exmem_stage: directed scenarios plus randomized traffic against
// a queue-based reference model of the stage contents.
module tb_exmem_stage;
  import exmem_pkg::*;

  localparam int W   = 32;
  localparam int RW  = 5;
  localparam int BeW = W / 8;
`ifdef EXMEM_SKID_EN
  localparam int Capacity = 2;
`else
  localparam int Capacity = 1;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  exmem_if #(.WordSize(W), .RegAddrW(RW)) bus ();

  exmem_stage #(.WordSize(W), .RegAddrW(RW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0]  rdn;
    logic [W-1:0]   alu;
    logic [W-1:0]   data;
    logic [BeW-1:0] be;
    logic           bt;
    mem_op_t        op;
    logic           mis;
  } exp_t;

  exp_t q[$];
  bit   acceptNow;

  // Expected payload straight from the alignment rules, using plain integer arithmetic.
  function automatic exp_t mkExp(input logic [RW-1:0] rdn, input logic [W-1:0] alu,
                                 input logic [W-1:0] rs2, input logic bt,
                                 input mem_op_t op, input mem_size_t sz);
    exp_t e;
    int   off, bytes, be;
    off    = int'(alu % (W / 8));
    bytes  = (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
    e.rdn  = rdn;
    e.alu  = alu;
    e.bt   = bt;
    e.op   = op;
    e.mis  = (op != MEM_NONE) && (off % bytes != 0);
    e.data = rs2 << (8 * off);
    be     = (op == MEM_STORE && !e.mis) ? (((1 << bytes) - 1) << off) : 0;
    e.be   = be[BeW-1:0];
    return e;
  endfunction

  function automatic bit expReady();
    if (Capacity == 2) return q.size() < 2;
    return (q.size() == 0) || (bus.out_ready == 1'b1);
  endfunction

  // Reference model: the stage as an ordered queue of at most Capacity entries.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
    end else if (bus.flush) begin
      q.delete();
    end else begin
      acceptNow = bus.in_valid && expReady();
      if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
      if (acceptNow)
        q.push_back(mkExp(bus.rdn_in, bus.alu_out_in, bus.rs2d, bus.branch_taken_in,
                          bus.mem_op_in, bus.mem_size_in));
    end
  end

  task automatic applyStimulus(input logic iv, input logic [RW-1:0] rdn, input logic [W-1:0] alu,
                               input logic [W-1:0] rs2, input logic bt, input mem_op_t op,
                               input mem_size_t sz, input logic fl, input logic ordy);
    @(negedge clk);
    bus.in_valid        = iv;
    bus.rdn_in          = rdn;
    bus.alu_out_in      = alu;
    bus.rs2d            = rs2;
    bus.branch_taken_in = bt;
    bus.mem_op_in       = op;
    bus.mem_size_in     = sz;
    bus.flush           = fl;
    bus.out_ready       = ordy;
    #1;
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, MEM_NONE, SIZE_BYTE, 1'b0, ordy);
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({bus.out_valid, bus.fwd_valid, bus.branch_taken, bus.misalign} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got %b want 0000",
               {bus.out_valid, bus.fwd_valid, bus.branch_taken, bus.misalign});
    end
    vectors++;
    if ({bus.rdn, bus.alu_out, bus.mem_data, bus.mem_op, bus.mem_be} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_payload got rdn=%h alu=%h data=%h op=%h be=%h want all 0",
               bus.rdn, bus.alu_out, bus.mem_data, bus.mem_op, bus.mem_be);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_store_align();
    applyStimulus(1'b1, 5'd3, 32'h0000_1002, 32'h0000_ABCD, 1'b0, MEM_STORE, SIZE_HALF, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd4, 32'h0000_1001, 32'h1234_5678, 1'b0, MEM_STORE, SIZE_WORD, 1'b0, 1'b1);
    vectors++;
    if ({bus.out_valid, bus.mem_data, bus.mem_be, bus.misalign} !== {1'b1, 32'hABCD_0000, 4'b1100, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL store_half got v=%b data=%h be=%b mis=%b want v=1 data=abcd0000 be=1100 mis=0",
               bus.out_valid, bus.mem_data, bus.mem_be, bus.misalign);
    end
    vectors++;
    if (bus.mem_op !== MEM_STORE) begin
      miscompares++;
      $display("[TB] FAIL store_half_op got %0d want %0d", bus.mem_op, MEM_STORE);
    end
    idle(1'b1);
    vectors++;
    if ({bus.out_valid, bus.mem_data, bus.mem_be, bus.misalign} !== {1'b1, 32'h3456_7800, 4'b0000, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL store_word_misalign got v=%b data=%h be=%b mis=%b want v=1 data=34567800 be=0000 mis=1",
               bus.out_valid, bus.mem_data, bus.mem_be, bus.misalign);
    end
    idle(1'b1);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL drain_empty got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_forwarding();
    applyStimulus(1'b1, 5'd7, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, MEM_LOAD, SIZE_WORD, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd7, 32'h0000_0055, 32'h0, 1'b1, MEM_NONE, SIZE_WORD, 1'b0, 1'b1);
    vectors++;
    if ({bus.out_valid, bus.fwd_valid, bus.fwd_rdn} !== {1'b1, 1'b0, 5'd7}) begin
      miscompares++;
      $display("[TB] FAIL fwd_load got v=%b fwd=%b rdn=%0d want v=1 fwd=0 rdn=7",
               bus.out_valid, bus.fwd_valid, bus.fwd_rdn);
    end
    applyStimulus(1'b1, 5'd0, 32'h0000_0066, 32'h0, 1'b0, MEM_NONE, SIZE_BYTE, 1'b0, 1'b1);
    vectors++;
    if ({bus.fwd_valid, bus.fwd_rdn, bus.fwd_data, bus.branch_taken} !== {1'b1, 5'd7, 32'h55, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL fwd_alu got fwd=%b rdn=%0d data=%h bt=%b want fwd=1 rdn=7 data=55 bt=1",
               bus.fwd_valid, bus.fwd_rdn, bus.fwd_data, bus.branch_taken);
    end
    idle(1'b1);
    vectors++;
    if ({bus.out_valid, bus.fwd_valid} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL fwd_rdn_zero got v=%b fwd=%b want v=1 fwd=0", bus.out_valid, bus.fwd_valid);
    end
    idle(1'b1);
    vectors++;
    if ({bus.out_valid, bus.fwd_valid, bus.branch_taken, bus.mem_be} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL gated_when_empty got v=%b fwd=%b bt=%b be=%b want all 0",
               bus.out_valid, bus.fwd_valid, bus.branch_taken, bus.mem_be);
    end
  endtask

  task automatic test_back_to_back_stall();
    int accepted = 0;
    int emerged  = 0;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, RW'(i + 1), W'($urandom), W'($urandom), 1'b0, MEM_NONE, SIZE_WORD, 1'b0, 1'b0);
      vectors++;
      if (bus.in_ready !== expReady()) begin
        miscompares++;
        $display("[TB] FAIL stall_in_ready cycle %0d got %b want %b", i, bus.in_ready, expReady());
      end
      if (bus.in_ready === 1'b1) accepted++;
    end
    vectors++;
    if (accepted != Capacity) begin
      miscompares++;
      $display("[TB] FAIL stall_accept_count got %0d want %0d", accepted, Capacity);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      if (q.size() > 0) begin
        e = q[0];
        vectors++;
        if ({bus.out_valid, bus.rdn, bus.alu_out} !== {1'b1, e.rdn, e.alu}) begin
          miscompares++;
          $display("[TB] FAIL stall_order got v=%b rdn=%0d alu=%h want v=1 rdn=%0d alu=%h",
                   bus.out_valid, bus.rdn, bus.alu_out, e.rdn, e.alu);
        end
        emerged++;
      end
    end
    vectors++;
    if (emerged != Capacity || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_drain got emerged=%0d v=%b want emerged=%0d v=0",
               emerged, bus.out_valid, Capacity);
    end
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, 5'd9, 32'h300, 32'h1, 1'b0, MEM_NONE, SIZE_WORD, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd10, 32'h400, 32'h2, 1'b0, MEM_NONE, SIZE_WORD, 1'b1, 1'b1);
    vectors++;
    if ({bus.out_valid, bus.rdn} !== {1'b1, 5'd9}) begin
      miscompares++;
      $display("[TB] FAIL flush_pre got v=%b rdn=%0d want v=1 rdn=9", bus.out_valid, bus.rdn);
    end
    applyStimulus(1'b1, 5'd11, 32'h500, 32'h3, 1'b0, MEM_NONE, SIZE_WORD, 1'b0, 1'b1);
    vectors++;
    if ({bus.out_valid, bus.fwd_valid} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL flush_clears got v=%b fwd=%b want 00", bus.out_valid, bus.fwd_valid);
    end
    idle(1'b1);
    vectors++;
    if ({bus.out_valid, bus.rdn, bus.alu_out} !== {1'b1, 5'd11, 32'h500}) begin
      miscompares++;
      $display("[TB] FAIL flush_discard got v=%b rdn=%0d alu=%h want v=1 rdn=11 alu=500",
               bus.out_valid, bus.rdn, bus.alu_out);
    end
    idle(1'b1);
  endtask

  task automatic test_random();
    exp_t e;
    logic expFwd;
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, RW'($urandom), W'($urandom), W'($urandom),
                    1'($urandom), mem_op_t'(2'($urandom_range(0, 2))),
                    mem_size_t'(2'($urandom_range(0, 2))), $urandom_range(0, 19) == 0,
                    $urandom_range(0, 3) != 0);
      vectors++;
      if ({bus.in_ready, bus.out_valid} !== {expReady(), q.size() != 0}) begin
        miscompares++;
        $display("[TB] FAIL rand_handshake cycle %0d got rdy=%b v=%b want rdy=%b v=%b",
                 i, bus.in_ready, bus.out_valid, expReady(), q.size() != 0);
      end
      if (q.size() != 0) begin
        e      = q[0];
        expFwd = (e.rdn != '0) && (e.op != MEM_LOAD);
        vectors++;
        if ({bus.rdn, bus.alu_out, bus.mem_data, bus.mem_be, bus.branch_taken, bus.mem_op, bus.misalign,
             bus.fwd_valid, bus.fwd_data} !==
            {e.rdn, e.alu, e.data, e.be, e.bt, e.op, e.mis, expFwd, e.alu}) begin
          miscompares++;
          $display("[TB] FAIL rand_payload cycle %0d got rdn=%0d alu=%h data=%h be=%b bt=%b op=%0d mis=%b fwd=%b want rdn=%0d alu=%h data=%h be=%b bt=%b op=%0d mis=%b fwd=%b",
                   i, bus.rdn, bus.alu_out, bus.mem_data, bus.mem_be, bus.branch_taken, bus.mem_op,
                   bus.misalign, bus.fwd_valid, e.rdn, e.alu, e.data, e.be, e.bt, e.op, e.mis, expFwd);
        end
      end else begin
        vectors++;
        if ({bus.branch_taken, bus.mem_be, bus.fwd_valid} !== '0) begin
          miscompares++;
          $display("[TB] FAIL rand_gating cycle %0d got bt=%b be=%b fwd=%b want 0",
                   i, bus.branch_taken, bus.mem_be, bus.fwd_valid);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, RW'(20 + i), W'($urandom), W'($urandom), 1'b1, MEM_STORE, SIZE_BYTE, 1'b0, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if ({bus.out_valid, bus.fwd_valid, bus.branch_taken, bus.misalign, bus.rdn, bus.alu_out,
         bus.mem_data, bus.mem_op, bus.mem_be} !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset got v=%b fwd=%b bt=%b mis=%b rdn=%0d alu=%h data=%h op=%0d be=%b want all 0",
               bus.out_valid, bus.fwd_valid, bus.branch_taken, bus.misalign, bus.rdn, bus.alu_out,
               bus.mem_data, bus.mem_op, bus.mem_be);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rstn          = 1'b1;
    #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL reset_release got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
  endtask

  initial begin
    bus.in_valid        = 1'b0;
    bus.rdn_in          = '0;
    bus.alu_out_in      = '0;
    bus.rs2d            = '0;
    bus.branch_taken_in = 1'b0;
    bus.mem_op_in       = MEM_NONE;
    bus.mem_size_in     = SIZE_BYTE;
    bus.flush           = 1'b0;
    bus.out_ready       = 1'b0;
    test_reset();
    test_store_align();
    test_forwarding();
    test_back_to_back_stall();
    test_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
